// File: rtl/relay_rr_arbiter_if.sv
// Producer-side FWFT read ports and downstream relay-station write port
// shared by the round-robin relay arbiter.
interface relay_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            in_empty_n;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout;
  logic [NUM_PORTS-1:0]            in_read;
  logic                            if_full_n;
  logic                            if_write;
  logic [DATA_WIDTH-1:0]           if_din;

  modport master (
    input  in_empty_n, in_dout, if_full_n,
    output in_read, if_write, if_din
  );

  modport slave (
    output in_empty_n, in_dout, if_full_n,
    input  in_read, if_write, if_din
  );
endinterface

// File: rtl/relay_rr_arbiter.sv
// Round-robin arbiter merging NUM_PORTS FWFT streams onto one relay-station
// write port through a registered output stage, with bounded grant bursts.
module relay_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  parameter int PTR_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  relay_rr_arbiter_if.master   bus,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_WIDTH-1:0] grant_idx,
  output logic                 busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [PTR_WIDTH-1:0]  prio;
  logic [PTR_WIDTH-1:0]  pick_idx;
  logic                  pick_valid;
  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] dout_arr [NUM_PORTS];
  logic                  cur_avail;
  logic                  out_rdy;
  logic                  pop;
  logic                  burst_done;
  logic                  rel;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dout_arr[i] = bus.in_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Descending scan so the last hit is the first set bit at or after prio.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (bus.in_empty_n[(int'(prio) + k) % NUM_PORTS]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_WIDTH'((int'(prio) + k) % NUM_PORTS);
      end
    end
  end

  assign cur_avail  = bus.in_empty_n[grant_idx];
  assign out_rdy    = ~bus.if_write | bus.if_full_n;
  assign pop        = (state == GRANT) & cur_avail & out_rdy;
  assign burst_done = pop & (cnt == 8'(MAX_BURST - 1));
  // A stalled downstream never releases; only burst end or a drained port do.
  assign rel        = (state == GRANT) & (burst_done | ~cur_avail);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = GRANT;
      GRANT:   if (rel)        state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_read = '0;
    if (pop) bus.in_read[grant_idx] = 1'b1;
    busy = (state == GRANT) | bus.if_write;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant     <= '0;
      grant_idx <= '0;
      prio      <= '0;
      cnt       <= '0;
    end else if ((state == IDLE) && pick_valid) begin
      grant     <= NUM_PORTS'(1) << pick_idx;
      grant_idx <= pick_idx;
      cnt       <= '0;
    end else if (rel) begin
      grant     <= '0;
      grant_idx <= '0;
      cnt       <= '0;
      prio      <= (grant_idx == PTR_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end else if (pop) begin
      cnt       <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.if_write <= 1'b0;
      bus.if_din   <= '0;
    end else if (pop) begin
      bus.if_write <= 1'b1;
      bus.if_din   <= dout_arr[grant_idx];
    end else if (bus.if_full_n) begin
      bus.if_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relay_rr_arbiter.sv
// Bench for relay_rr_arbiter: queue-backed FWFT producers, a cycle reference
// model of the arbitration rules, and a per-port in-order delivery scoreboard.
module tb_relay_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int PW = 2;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  grant;
  logic [PW-1:0] grant_idx;
  logic          busy;
  int            n_cmp = 0;
  int            n_err = 0;

  relay_rr_arbiter_if #(.NUM_PORTS(N), .DATA_WIDTH(DW)) bus();

  relay_rr_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Producer FIFOs; each word is {port[7:0], sequence[23:0]}.
  logic [DW-1:0] fifo [N][$];
  int            next_seq [N];
  int            exp_seq  [N];

  // Reference model state.
  bit            m_granted;
  int            m_g, m_cnt, m_prio;
  bit            m_wr;
  logic [DW-1:0] m_din;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input int n);
    repeat (n) begin
      fifo[p].push_back({8'(p), 24'(next_seq[p])});
      next_seq[p]++;
    end
  endtask

  task automatic model_reset();
    m_granted = 1'b0;
    m_g       = 0;
    m_cnt     = 0;
    m_prio    = 0;
    m_wr      = 1'b0;
    m_din     = '0;
  endtask

  task automatic cycle(input bit full_n);
    bit            avail [N];
    bit            exp_pop;
    logic [N-1:0]  rd;
    logic [DW-1:0] head;
    int            p;
    int            j;
    @(negedge clk);
    bus.if_full_n = full_n;
    for (int i = 0; i < N; i++) begin
      avail[i]              = fifo[i].size() != 0;
      bus.in_empty_n[i]     = avail[i];
      bus.in_dout[i*DW +: DW] = avail[i] ? fifo[i][0] : '0;
    end
    #1;
    exp_pop = m_granted && avail[m_g] && (!m_wr || full_n);
    check("grant",     64'(grant),       m_granted ? 64'(N'(1) << m_g) : 64'(0));
    check("grant_idx", 64'(grant_idx),   m_granted ? 64'(m_g) : 64'(0));
    check("in_read",   64'(bus.in_read), exp_pop ? 64'(N'(1) << m_g) : 64'(0));
    check("if_write",  64'(bus.if_write), 64'(m_wr));
    check("if_din",    64'(bus.if_din),  64'(m_din));
    check("busy",      64'(busy),        64'(m_granted || m_wr));
    if (bus.if_write && full_n) begin
      p = int'(bus.if_din[31:24]);
      check("port_tag", 64'(p < N), 64'(1));
      if (p < N) begin
        check("order", 64'(bus.if_din[23:0]), 64'(24'(exp_seq[p])));
        exp_seq[p] = int'(bus.if_din[23:0]) + 1;
      end
    end
    rd   = bus.in_read;
    head = avail[m_g] ? fifo[m_g][0] : '0;
    @(posedge clk);
    if (!m_granted) begin
      for (int k = 0; k < N; k++) begin
        j = (m_prio + k) % N;
        if (avail[j]) begin
          m_granted = 1'b1;
          m_g       = j;
          m_cnt     = 0;
          break;
        end
      end
    end else if ((exp_pop && m_cnt == MB - 1) || !avail[m_g]) begin
      m_granted = 1'b0;
      m_prio    = (m_g + 1) % N;
      m_cnt     = 0;
    end else if (exp_pop) begin
      m_cnt++;
    end
    if (exp_pop) begin
      m_wr  = 1'b1;
      m_din = head;
    end else if (full_n) begin
      m_wr  = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (rd[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    end
  endtask

  // Asynchronous half-cycle reset pulse; the held output word is discarded.
  task automatic pulse_reset();
    @(negedge clk);
    #1;
    check("pre_reset_if_write", 64'(bus.if_write), 64'(m_wr));
    #1 reset_n = 1'b0;
    #1;
    check("rst_grant",     64'(grant),        64'(0));
    check("rst_grant_idx", 64'(grant_idx),    64'(0));
    check("rst_in_read",   64'(bus.in_read),  64'(0));
    check("rst_if_write",  64'(bus.if_write), 64'(0));
    check("rst_if_din",    64'(bus.if_din),   64'(0));
    check("rst_busy",      64'(busy),         64'(0));
    if (m_wr) exp_seq[m_din[31:24]] = int'(m_din[23:0]) + 1;
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int guard;
    int left;
    bus.in_empty_n = '0;
    bus.in_dout    = '0;
    bus.if_full_n  = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      next_seq[i] = 0;
      exp_seq[i]  = 0;
    end

    #12;
    check("init_grant",     64'(grant),        64'(0));
    check("init_grant_idx", 64'(grant_idx),    64'(0));
    check("init_in_read",   64'(bus.in_read),  64'(0));
    check("init_if_write",  64'(bus.if_write), 64'(0));
    check("init_if_din",    64'(bus.if_din),   64'(0));
    check("init_busy",      64'(busy),         64'(0));
    #5 reset_n = 1'b1;

    // Single port: three words on port 1, downstream always ready.
    push(1, 3);
    repeat (8) cycle(1'b1);

    // Burst limit: port 0 long queue, port 2 short queue.
    push(0, 10);
    push(2, 2);
    repeat (30) cycle(1'b1);

    // Fairness: every port kept non-empty.
    repeat (24) begin
      for (int i = 0; i < N; i++) if (fifo[i].size() < 2) push(i, 2);
      cycle(1'b1);
    end
    repeat (8) cycle(1'b1);

    // Backpressure: downstream full for five cycles mid-burst.
    push(3, 8);
    repeat (3) cycle(1'b1);
    repeat (5) cycle(1'b0);
    repeat (12) cycle(1'b1);

    // Drain release: port 2 empties before its burst ends.
    push(2, 2);
    push(0, 3);
    repeat (12) cycle(1'b1);

    // Randomised traffic and downstream readiness.
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0 && fifo[i].size() < 6) push(i, $urandom_range(1, 5));
      cycle($urandom_range(0, 3) != 0);
    end

    // Asynchronous reset while the output register holds a word.
    push(0, 6);
    push(1, 4);
    guard = 0;
    while (!m_wr && guard < 50) begin
      cycle(1'b1);
      guard++;
    end
    check("reset_setup", 64'(m_wr), 64'(1));
    pulse_reset();
    repeat (20) cycle(1'b1);

    // Drain everything that is left.
    guard = 0;
    left  = 1;
    while (left != 0 && guard < 300) begin
      cycle(1'b1);
      guard++;
      left = (m_wr || m_granted) ? 1 : 0;
      for (int i = 0; i < N; i++) left += fifo[i].size();
    end
    check("drained", 64'(left), 64'(0));
    for (int i = 0; i < N; i++) check($sformatf("delivered_p%0d", i), 64'(exp_seq[i]), 64'(next_seq[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
